// File: rtl/alu_exec_stage.sv
// Execute stage: registered ALU result and flags under a valid/ready handshake.
// Define ALU_MUL_EN to build the iterative shift-add multiplier; otherwise MUL reports illegal.
module alu_exec_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSrl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

`ifdef ALU_MUL_EN
  localparam bit MulBuilt = 1'b1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StHold = 2'd2} state_e;
`else
  localparam bit MulBuilt = 1'b0;
  typedef enum logic [1:0] {StIdle = 2'd0, StHold = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             mul_start;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  // Single-cycle ALU on the live operands; only consumed on an accept edge.
  always_comb begin
    add_full = {1'b0, r1} + {1'b0, r3};
    sub_full = {1'b0, r1} - {1'b0, r3};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    case (aluop)
      OpAdd: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (r1[Msb] == r3[Msb]) && (add_full[Msb] != r1[Msb]);
      end
      OpSub: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];  // borrow out of the extended subtract
        alu_v   = (r1[Msb] != r3[Msb]) && (sub_full[Msb] != r1[Msb]);
      end
      OpAnd:   alu_res = r1 & r3;
      OpOr:    alu_res = r1 | r3;
      OpXor:   alu_res = r1 ^ r3;
      OpSll:   alu_res = r1 << r3[SHAMT_W-1:0];
      OpSrl:   alu_res = r1 >> r3[SHAMT_W-1:0];
      default: alu_ill = ~MulBuilt;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]     part_sum;
  logic [2*WIDTH-1:0] acc_step;

  // Low half of acc holds the remaining multiplier bits; the product shifts in from the top.
  always_comb begin
    part_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {part_sum, acc_q[WIDTH-1:1]};
  end

  assign mul_start = (aluop == OpMul);
`else
  assign mul_start = 1'b0;
`endif

  assign in_ready = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
`ifdef ALU_MUL_EN
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
`endif

    if (accept && !mul_start) begin
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      carry_d    = alu_c;
      overflow_d = alu_v;
      illegal_d  = alu_ill;
      state_d    = StHold;
    end else if ((state_q == StHold) && out_ready && !in_valid) begin
      state_d = StIdle;
    end

`ifdef ALU_MUL_EN
    if (accept && mul_start) begin
      acc_d   = {{WIDTH{1'b0}}, r3};
      mcand_d = r1;
      cnt_d   = CntW'(WIDTH);
      state_d = StBusy;
    end

    if (state_q == StBusy) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        result_d   = acc_step[WIDTH-1:0];
        zero_d     = (acc_step[WIDTH-1:0] == '0);
        carry_d    = |acc_step[2*WIDTH-1:WIDTH];
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
        state_d    = StHold;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q      <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
`ifdef ALU_MUL_EN
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == StHold);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage; covers both ALU_MUL_EN builds.
module tb_alu_exec_stage;

  localparam int unsigned W = 32;

`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   aluop;
  logic [W-1:0] r1;
  logic [W-1:0] r3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_exec_stage #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .r1        (r1),
    .r3        (r3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c,
                              input logic v, input logic il);
    exp_t e;
    e.res = r;
    e.z   = z;
    e.c   = c;
    e.v   = v;
    e.ill = il;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] wide;
    e = '0;
    case (op)
      3'd0: begin
        wide  = {32'b0, a} + {32'b0, b};
        e.res = wide[31:0];
        e.c   = wide[32];
        e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a < b);
        e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = a << b[4:0];
      3'd6: e.res = a >> b[4:0];
      default: begin
        if (MulEn) begin
          wide  = {32'b0, a} * {32'b0, b};
          e.res = wide[31:0];
          e.c   = |wide[63:32];
        end else begin
          e.ill = 1'b1;
        end
      end
    endcase
    e.z = (e.res == 32'b0);
    return e;
  endfunction

  // Presents an op and waits (bounded) for the accept edge; returns on the negedge after it.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, output int waited);
    in_valid = 1'b1;
    aluop    = op;
    r1       = a;
    r3       = b;
    waited   = 0;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'(1));
    else exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Output side: a transfer completes at the posedge following this sample.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("result", 64'(result), 64'(e.res));
        check_eq("zero", 64'(zero), 64'(e.z));
        check_eq("carry", 64'(carry), 64'(e.c));
        check_eq("overflow", 64'(overflow), 64'(e.v));
        check_eq("illegal", 64'(illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int    w;
    int    n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    aluop     = 3'd0;
    r1        = '0;
    r3        = '0;
    #1 rst_n  = 1'b0;
    #1;
    // Asynchronous reset, before any clock edge.
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_result", 64'(result), 64'(0));
    check_eq("rst_flags", 64'({zero, carry, overflow, illegal}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));

    // ADD/SUB flag corners, issued back to back.
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 0, 1, 0), w);
    #1;
    check_eq("latency1_out_valid", 64'(out_valid), 64'(1));
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1, 1, 0, 0), w);
    check_eq("b2b_wait_add", 64'(w), 64'(0));
    send(3'd1, 32'h0000_0001, 32'h0000_0002, mk(32'hFFFF_FFFF, 0, 1, 0, 0), w);
    check_eq("b2b_wait_sub", 64'(w), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("hold_to_idle", 64'(out_valid), 64'(0));

    // Shifts back to back; upper shift-amount bits ignored.
    send(3'd5, 32'h0000_0001, 32'hFFFF_001F, mk(32'h8000_0000, 0, 0, 0, 0), w);
    #1;
    check_eq("sll_in_ready", 64'(in_ready), 64'(1));
    check_eq("sll_out_valid", 64'(out_valid), 64'(1));
    send(3'd6, 32'h8000_0000, 32'h0000_0004, mk(32'h0800_0000, 0, 0, 0, 0), w);
    check_eq("srl_wait", 64'(w), 64'(0));
    #1;
    check_eq("srl_out_valid", 64'(out_valid), 64'(1));
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: output held, next op stalled, then accepted exactly once.
    out_ready = 1'b0;
    send(3'd4, 32'hFFFF_FFFF, 32'h0000_FFFF, mk(32'hFFFF_0000, 0, 0, 0, 0), w);
    aluop = 3'd0;
    r1    = 32'd5;
    r3    = 32'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_result", 64'(result), 64'(32'hFFFF_0000));
      check_eq("bp_out_valid", 64'(out_valid), 64'(1));
      check_eq("bp_in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(3'd0, 32'd5, 32'd6, mk(32'd11, 0, 0, 0, 0), w);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("bp_drained", 64'(exp_q.size()), 64'(0));
    check_eq("bp_idle", 64'(out_valid), 64'(0));

    // Opcode 111.
    if (MulEn) begin
      send(3'd7, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 1, 1, 0, 0), w);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
        check_eq("busy_in_ready", 64'(in_ready), 64'(0));
        r1 = $urandom;
        r3 = $urandom;
        @(negedge clk);
        #1;
        n++;
      end
      check_eq("mul_latency", 64'(n), 64'(W));
      send(3'd7, 32'h0000_1234, 32'h0000_0010, mk(32'h0001_2340, 0, 0, 0, 0), w);
      in_valid = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
      // Reset in the middle of a multiply: that op must never complete.
      send(3'd7, 32'hDEAD_BEEF, 32'h1234_5678, model(3'd7, 32'hDEAD_BEEF, 32'h1234_5678), w);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_eq("midbusy_out_valid", 64'(out_valid), 64'(0));
      check_eq("midbusy_result", 64'(result), 64'(0));
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 40; k++) begin
        #1;
        if (out_valid) n++;
        @(negedge clk);
      end
      check_eq("aborted_mul_silent", 64'(n), 64'(0));
    end else begin
      send(3'd7, 32'hDEAD_BEEF, 32'h1234_5678, mk(32'h0, 1, 0, 0, 1), w);
      #1;
      check_eq("illegal_latency", 64'(out_valid), 64'(1));
      in_valid = 1'b0;
      @(negedge clk);
    end

    // Async reset while holding an output.
    out_ready = 1'b0;
    send(3'd2, 32'hFFFF_FFFF, 32'h0F0F_0F0F, mk(32'h0F0F_0F0F, 0, 0, 0, 0), w);
    in_valid = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("hold_rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("hold_rst_result", 64'(result), 64'(0));
    check_eq("hold_rst_flags", 64'({zero, carry, overflow, illegal}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // Random ops with occasional gaps.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      send(op, a, b, model(op, a, b), w);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check_eq("final_drain", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage sitting directly downstream of the ALU operand-B source mux.
- Consumes operand A (r1) from the register file and operand B (r3, already register-or-immediate selected) plus a 3-bit opcode.
- Produces a registered result and flags under a valid/ready handshake.
- Single-cycle logic/arith ops; iterative shift-add multiply.

Parameters:
- WIDTH, 32, datapath width of r1/r3/result.
- SHAMT_W, 5, shift-amount bits taken from r3[SHAMT_W-1:0]; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  opcode/operands valid
- in_ready  output  1  stage can accept this cycle (combinational)
- aluop  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL
- r1  input  WIDTH  operand A
- r3  input  WIDTH  operand B (mux output)
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- carry  output  1  ADD carry-out / SUB borrow / MUL high-half nonzero
- overflow  output  1  signed overflow (ADD/SUB only)
- illegal  output  1  opcode not supported in this build

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. On reset assertion, state=IDLE and result, zero, carry, overflow, illegal, out_valid and the multiply counter are all 0, immediately and regardless of clk.
- Reset mid-multiply aborts the operation; no partial result is ever presented.
- States:
  - IDLE (output empty)
  - BUSY (multiply iterating)
  - HOLD (out_valid=1)
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is never high in BUSY.
- Accept occurs when in_valid && in_ready at a clk edge; operands and opcode are sampled at that edge only.
- Single-cycle ops: result and flags are registered at the accept edge; state becomes HOLD, so out_valid is high in the next cycle (latency 1).
- Back-to-back operation: in HOLD with out_ready=1 and in_valid=1, the new op is accepted and the output register overwritten on the same edge. Throughput is 1 op per cycle.
- HOLD with out_ready=1 and in_valid=0 moves to IDLE; out_valid drops next cycle.
- HOLD with out_ready=0: result and flags are held stable and nothing is accepted.
- Arithmetic rules:
  - ADD: {carry,result}=r1+r3. overflow=(r1[MSB]==r3[MSB])&&(result[MSB]!=r1[MSB]).
  - SUB: result=r1-r3. carry=1 iff r1<r3 unsigned. overflow=(r1[MSB]!=r3[MSB])&&(result[MSB]!=r1[MSB]).
  - AND/OR/XOR: carry=0, overflow=0.
  - SLL/SRL: logical shift by r3[SHAMT_W-1:0]; upper r3 bits ignored; shift 0 passes r1; carry=0, overflow=0.
  - MUL: unsigned WIDTH x WIDTH -> 2*WIDTH; result = low half; carry = |high half; overflow=0.
- zero is computed from the registered result for every op.
- MUL sequencing: the accept edge loads the multiplicand, multiplier, a 2*WIDTH accumulator, and cnt=WIDTH, then enters BUSY. Each BUSY edge performs one shift-add step and decrements cnt. The edge at which cnt reaches 0 writes result/flags and enters HOLD. out_valid is first high WIDTH cycles after the accept edge (32 for default).
- Operands changing during BUSY have no effect.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL behaves as above; illegal is always 0.
- Undefined: no multiplier datapath or BUSY state is built. aluop 111 completes in 1 cycle with result=0, zero=1, carry=0, overflow=0, illegal=1. illegal is 0 for all other ops.
- Ports are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with no clk edges -> out_valid=0, result=0, all flags 0, in_ready=1 after release.
- ADD/SUB flags:
  - ADD r1=0x7FFFFFFF, r3=0x00000001 -> result 0x80000000, overflow=1, carry=0.
  - ADD 0xFFFFFFFF+0x00000001 -> result 0, zero=1, carry=1.
  - SUB r1=0x00000001, r3=0x00000002 -> result 0xFFFFFFFF, carry=1.
- Shifts and back-to-back: out_ready=1 held; SLL r1=0x00000001, r3=0xFFFF001F -> 0x80000000. Next cycle SRL r1=0x80000000, r3=0x00000004 -> 0x08000000. in_ready stays 1 throughout and out_valid is high on consecutive cycles.
- Backpressure: XOR r1=0xFFFFFFFF, r3=0x0000FFFF with out_ready=0 for 5 cycles -> result 0xFFFF0000 stable, in_ready=0; raise out_ready -> accepted once.
- MUL (ALU_MUL_EN defined): r1=0x00010000, r3=0x00010000 -> in_ready=0 for 32 cycles, then result 0, zero=1, carry=1. Also r1=0x1234, r3=0x10 -> 0x12340, carry=0. Assert rst_n low mid-BUSY -> out_valid never rises for that op.
- MUL (ALU_MUL_EN undefined): aluop 111 with any operands -> 1-cycle latency, illegal=1, result 0.
